// File: rtl/nios2_mult_pipe.sv
// nios2_mult_pipe
//   Pipelined DATA_W x DATA_W multiplier for the four Nios II multiply
//   flavours. The product is built from SLICE_W x SLICE_W partial products.
//   The result is valid PIPE_STAGES enabled cycles after the operands are
//   captured.
//
// Ports
//   clk           clock
//   reset_n       asynchronous active-low reset, clears every stage
//   E_src1        multiplicand (rs)
//   E_src2        multiplier (rt)
//   E_op          00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   E_valid       operands/op valid this cycle
//   M_en          advance enable; 0 holds every stage
//   flush         clears all in-flight valid bits on the next edge
//   M_mul_result  selected result word (last computed value when not valid)
//   M_mul_valid   M_mul_result is valid
module nios2_mult_pipe #(
   parameter int DATA_W      = 32,
   parameter int SLICE_W     = 16,
   parameter int PIPE_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] E_src1,
   input  logic [DATA_W-1:0] E_src2,
   input  logic [1:0]        E_op,
   input  logic              E_valid,
   input  logic              M_en,
   input  logic              flush,
   output logic [DATA_W-1:0] M_mul_result,
   output logic              M_mul_valid
);

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULXUU = 2'b01,
      OP_MULXSU = 2'b10,
      OP_MULXSS = 2'b11
   } op_e;

   localparam int unsigned NSL = DATA_W / SLICE_W;
   localparam int unsigned PW  = 2 * SLICE_W;
   localparam int unsigned PPW = NSL * NSL * PW;
   localparam int unsigned UW  = 2 * DATA_W;

   // All NSL*NSL slice products, packed with pp[i][j] at index i*NSL+j.
   function automatic logic [PPW-1:0] form_pp(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      logic [PPW-1:0] pp;
      logic [PW-1:0]  ai;
      logic [PW-1:0]  bj;
      pp = '0;
      for (int unsigned i = 0; i < NSL; i++) begin
         for (int unsigned j = 0; j < NSL; j++) begin
            ai = PW'(a[i*SLICE_W +: SLICE_W]);
            bj = PW'(b[j*SLICE_W +: SLICE_W]);
            pp[(i*NSL+j)*PW +: PW] = ai * bj;
         end
      end
      return pp;
   endfunction

   // Unsigned full product: each pp[i][j] weighted by 2^((i+j)*SLICE_W).
   function automatic logic [UW-1:0] sum_pp(input logic [PPW-1:0] pp);
      logic [UW-1:0] acc;
      logic [UW-1:0] term;
      acc = '0;
      for (int unsigned i = 0; i < NSL; i++) begin
         for (int unsigned j = 0; j < NSL; j++) begin
            term = UW'(pp[(i*NSL+j)*PW +: PW]);
            acc  = acc + (term << ((i + j) * SLICE_W));
         end
      end
      return acc;
   endfunction

   // Signed high words come from the unsigned product: a negative operand
   // contributes -2^W * (other operand), which only touches the high word.
   function automatic logic [DATA_W-1:0] pick_result(input logic [UW-1:0]     u,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input op_e               op);
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] corr_a;
      logic [DATA_W-1:0] corr_b;
      logic [DATA_W-1:0] res;
      hi     = u[UW-1:DATA_W];
      corr_a = a[DATA_W-1] ? b : '0;
      corr_b = b[DATA_W-1] ? a : '0;
      case (op)
         OP_MUL:    res = u[DATA_W-1:0];
         OP_MULXUU: res = hi;
         OP_MULXSU: res = hi - corr_a;
         OP_MULXSS: res = hi - corr_a - corr_b;
         default:   res = u[DATA_W-1:0];
      endcase
      return res;
   endfunction

   generate
      if (PIPE_STAGES == 1) begin : g_single
         logic [DATA_W-1:0] res_q;
         logic              vld_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               res_q <= '0;
               vld_q <= 1'b0;
            end else begin
               if (M_en)
                  res_q <= pick_result(sum_pp(form_pp(E_src1, E_src2)),
                                       E_src1, E_src2, op_e'(E_op));
               if (flush)
                  vld_q <= 1'b0;
               else if (M_en)
                  vld_q <= E_valid;
            end
         end

         assign M_mul_result = res_q;
         assign M_mul_valid  = vld_q;
      end else begin : g_multi
         // Stage 1 holds partial products; res_q[0] is stage 2 (sum and
         // signed correction); res_q[k>0] are pure delay stages.
         localparam int unsigned ND = PIPE_STAGES - 1;

         logic [PPW-1:0]    s1_pp;
         logic [DATA_W-1:0] s1_a;
         logic [DATA_W-1:0] s1_b;
         op_e               s1_op;
         logic              s1_vld;
         logic [DATA_W-1:0] res_q [ND];
         logic              vld_q [ND];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s1_pp  <= '0;
               s1_a   <= '0;
               s1_b   <= '0;
               s1_op  <= OP_MUL;
               s1_vld <= 1'b0;
               for (int unsigned k = 0; k < ND; k++) begin
                  res_q[k] <= '0;
                  vld_q[k] <= 1'b0;
               end
            end else begin
               if (M_en) begin
                  s1_pp    <= form_pp(E_src1, E_src2);
                  s1_a     <= E_src1;
                  s1_b     <= E_src2;
                  s1_op    <= op_e'(E_op);
                  res_q[0] <= pick_result(sum_pp(s1_pp), s1_a, s1_b, s1_op);
                  for (int unsigned k = 1; k < ND; k++)
                     res_q[k] <= res_q[k-1];
               end
               // Flush wins over stall: valids clear even when data holds.
               if (flush) begin
                  s1_vld <= 1'b0;
                  for (int unsigned k = 0; k < ND; k++)
                     vld_q[k] <= 1'b0;
               end else if (M_en) begin
                  s1_vld   <= E_valid;
                  vld_q[0] <= s1_vld;
                  for (int unsigned k = 1; k < ND; k++)
                     vld_q[k] <= vld_q[k-1];
               end
            end
         end

         assign M_mul_result = res_q[ND-1];
         assign M_mul_valid  = vld_q[ND-1];
      end
   endgenerate

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Scoreboard bench for nios2_mult_pipe. Three configurations share one
// stimulus stream: 32/16/2, 64/16/3 and 32/8/1. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_nios2_mult_pipe;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] a64;
   logic [63:0] b64;
   logic [1:0]  op;
   logic        v;
   logic        en;
   logic        fl;

   logic [31:0] r0;
   logic [63:0] r1;
   logic [31:0] r2;
   logic        v0;
   logic        v1;
   logic        v2;

   always #5 clk = ~clk;

   nios2_mult_pipe #(.DATA_W(32), .SLICE_W(16), .PIPE_STAGES(2)) u_d0 (
      .clk(clk), .reset_n(reset_n), .E_src1(a64[31:0]), .E_src2(b64[31:0]),
      .E_op(op), .E_valid(v), .M_en(en), .flush(fl),
      .M_mul_result(r0), .M_mul_valid(v0));

   nios2_mult_pipe #(.DATA_W(64), .SLICE_W(16), .PIPE_STAGES(3)) u_d1 (
      .clk(clk), .reset_n(reset_n), .E_src1(a64), .E_src2(b64),
      .E_op(op), .E_valid(v), .M_en(en), .flush(fl),
      .M_mul_result(r1), .M_mul_valid(v1));

   nios2_mult_pipe #(.DATA_W(32), .SLICE_W(8), .PIPE_STAGES(1)) u_d2 (
      .clk(clk), .reset_n(reset_n), .E_src1(a64[31:0]), .E_src2(b64[31:0]),
      .E_op(op), .E_valid(v), .M_en(en), .flush(fl),
      .M_mul_result(r2), .M_mul_valid(v2));

   typedef struct {
      logic [63:0] val;
      int unsigned cap;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        q2[$];
   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned en_cnt   = 0;
   int unsigned accepted = 0;

   function automatic int unsigned dut_w(input int d);
      return (d == 1) ? 64 : 32;
   endfunction

   function automatic int unsigned dut_p(input int d);
      case (d)
         0:       return 2;
         1:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic logic [63:0] dut_res(input int d);
      case (d)
         0:       return {32'd0, r0};
         1:       return r1;
         default: return {32'd0, r2};
      endcase
   endfunction

   function automatic logic dut_vld(input int d);
      case (d)
         0:       return v0;
         1:       return v1;
         default: return v2;
      endcase
   endfunction

   // Reference: exact integer products in 128 bits, then take the word.
   function automatic logic [63:0] ref_mul(input int unsigned w, input logic [63:0] a,
                                           input logic [63:0] b, input logic [1:0] o);
      logic [127:0] mask;
      logic [127:0] ua;
      logic [127:0] ub;
      logic [127:0] sa;
      logic [127:0] sb;
      logic [127:0] p;
      mask = (128'd1 << w) - 128'd1;
      ua   = {64'd0, a} & mask;
      ub   = {64'd0, b} & mask;
      sa   = a[w-1] ? (ua | ~mask) : ua;
      sb   = b[w-1] ? (ub | ~mask) : ub;
      case (o)
         2'b00:   p = ua * ub;
         2'b01:   p = (ua * ub) >> w;
         2'b10:   p = (sa * ub) >> w;
         default: p = (sa * sb) >> w;
      endcase
      return 64'(p & mask);
   endfunction

   task automatic check(input string name, input int d, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d got=%h exp=%h", name, d, got, exp);
      end
   endtask

   task automatic pop_check(input int d);
      exp_t e;
      logic have;
      have = 1'b1;
      case (d)
         0:       if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
         1:       if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
         default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
      endcase
      if (!have) begin
         checks++;
         failures++;
         $display("FAIL spurious_valid dut%0d got=1 exp=0", d);
      end else begin
         check("result", d, dut_res(d), e.val);
         check("latency", d, 64'(en_cnt - e.cap), 64'(dut_p(d)));
      end
   endtask

   task automatic clear_queues();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   // One cycle of stimulus; the expected result is queued for the edge that
   // captures it, tagged with the enabled-edge count before that edge.
   task automatic drive(input logic vv, input logic [1:0] oo, input logic [63:0] aa,
                        input logic [63:0] bb, input logic ee, input logic ff);
      @(negedge clk);
      v   = vv;
      op  = oo;
      a64 = aa;
      b64 = bb;
      en  = ee;
      fl  = ff;
      if (ff) begin
         clear_queues();
      end else if (ee && vv && reset_n) begin
         accepted++;
         q0.push_back('{val: ref_mul(32, aa, bb, oo), cap: en_cnt});
         q1.push_back('{val: ref_mul(64, aa, bb, oo), cap: en_cnt});
         q2.push_back('{val: ref_mul(32, aa, bb, oo), cap: en_cnt});
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++)
         drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
   endtask

   function automatic logic [63:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_8000_0000;
         3:       return {32'h7FFF_FFFF, 32'h7FFF_FFFF};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Monitor: pops on every enabled edge with a valid output; on stalled
   // edges the outputs must hold, except that flush drops the valid.
   initial begin : monitor
      logic [63:0] prev_r [3];
      logic        prev_v [3];
      for (int d = 0; d < 3; d++) begin
         prev_r[d] = '0;
         prev_v[d] = 1'b0;
      end
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            for (int d = 0; d < 3; d++) begin
               prev_r[d] = '0;
               prev_v[d] = 1'b0;
            end
            continue;
         end
         if (en)
            en_cnt++;
         for (int d = 0; d < 3; d++) begin
            if (en) begin
               if (dut_vld(d))
                  pop_check(d);
            end else begin
               check("stall_result", d, dut_res(d), prev_r[d]);
               check("stall_valid", d, 64'(dut_vld(d)), 64'(prev_v[d] && !fl));
            end
            prev_r[d] = dut_res(d);
            prev_v[d] = dut_vld(d);
         end
      end
   end

   initial begin : stimulus
      reset_n = 1'b0;
      v       = 1'b0;
      op      = 2'b00;
      a64     = '0;
      b64     = '0;
      en      = 1'b0;
      fl      = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_result", d, dut_res(d), 64'd0);
         check("reset_valid", d, 64'(dut_vld(d)), 64'd0);
      end
      reset_n = 1'b1;

      // Directed arithmetic cases
      drive(1'b1, 2'b00, 64'h0000_0000_0001_0003, 64'h0000_0000_0002_0005, 1'b1, 1'b0);
      drive(1'b1, 2'b11, '1, 64'd2, 1'b1, 1'b0);
      drive(1'b1, 2'b01, '1, 64'd2, 1'b1, 1'b0);
      drive(1'b1, 2'b10, '1, 64'd2, 1'b1, 1'b0);
      drive(1'b1, 2'b11, 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 1'b1, 1'b0);
      drive(1'b1, 2'b00, 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 1'b1, 1'b0);
      drive(1'b1, 2'b10, 64'h0000_0003_8000_0001, '1, 1'b1, 1'b0);
      idle(5);

      // Back-to-back ops with a 3-cycle stall after the first capture
      drive(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 1'b1, 1'b0);
      repeat (3) drive(1'b1, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
      drive(1'b1, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b0);
      drive(1'b1, 2'b10, 64'hCAFE_0000_F00D_0001, 64'h0000_FFFF_1111_2222, 1'b1, 1'b0);
      idle(5);

      // Flush of an op at stage 1, then a normal op
      drive(1'b1, 2'b00, 64'd12345, 64'd678, 1'b1, 1'b0);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b1, 1'b1);
      drive(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
      idle(5);
      // Flush together with E_valid drops the op
      drive(1'b1, 2'b01, 64'd99, 64'd77, 1'b1, 1'b1);
      idle(5);
      // Flush during a stall: valids clear, data holds
      drive(1'b1, 2'b11, 64'h0000_0000_8765_4321, 64'h0000_0000_0000_00FF, 1'b1, 1'b0);
      drive(1'b1, 2'b01, 64'd5, 64'd5, 1'b1, 1'b0);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b0);
      idle(5);

      // Asynchronous reset with ops in flight
      for (int i = 0; i < 4; i++)
         drive(1'b1, 2'(i), {$urandom, $urandom} | 64'h1, {$urandom, $urandom} | 64'h1, 1'b1, 1'b0);
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      clear_queues();
      #1;
      for (int d = 0; d < 3; d++) begin
         check("async_reset_result", d, dut_res(d), 64'd0);
         check("async_reset_valid", d, 64'(dut_vld(d)), 64'd0);
      end
      repeat (2) @(negedge clk);
      v       = 1'b0;
      reset_n = 1'b1;
      idle(2);

      // Random traffic
      accepted = 0;
      for (int unsigned n = 0; n < 20000 && accepted < 10000; n++) begin
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd_operand(),
               rnd_operand(), $urandom_range(0, 4) != 0, $urandom_range(0, 31) == 0);
      end
      idle(8);

      check("drain", 0, 64'(q0.size()), 64'd0);
      check("drain", 1, 64'(q1.size()), 64'd0);
      check("drain", 2, 64'(q2.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
